// File: rtl/stack_arbiter.sv
// rtl/stack_arbiter.sv - two-port round-robin sequencer for the 8-bit, 256-entry hardware stack
//
// Purpose: accepts push/pop/peek requests from two requesters and grants them
// round-robin. It drives single-cycle POP/PUSH strobes to the stack block and
// captures popped words. It tracks occupancy so that overflow and underflow
// are rejected before they reach the stack pointer.
//
// Optional feature macro: STACK_ARB_PEEK_EN
//   defined   - op 2'b10 is a peek: pop, then re-push the same word (REPUSH state).
//   undefined - op 2'b10 is rejected with ack+err one cycle after it is sampled.
//
// Ports:
//   clk              system clock, rising edge
//   rst              asynchronous active-low reset
//   req0/req1        level request; op/wdata held stable until ack
//   op0/op1          00 push, 01 pop, 10 peek, 11 reserved
//   wdata0/wdata1    push data
//   ack0/ack1        one-cycle completion pulse
//   err0/err1        valid with ack; op was rejected
//   rdata0/rdata1    last popped/peeked word for that port, held
//   stk_pop          to stack POP
//   stk_push         to stack PUSH
//   stk_value        to stack VALUE (0 when not pushing)
//   stk_output       from stack OUTPUT, valid combinationally while stk_pop=1
//   depth            occupancy 0..256
//   full / empty     depth==256 / depth==0

module stack_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [1:0] op0,
    input  logic [1:0] op1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       ack0,
    output logic       ack1,
    output logic       err0,
    output logic       err1,
    output logic [7:0] rdata0,
    output logic [7:0] rdata1,
    output logic       stk_pop,
    output logic       stk_push,
    output logic [7:0] stk_value,
    input  logic [7:0] stk_output,
    output logic [8:0] depth,
    output logic       full,
    output logic       empty
);

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_PEEK = 2'b10;

`ifdef STACK_ARB_PEEK_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_DONE   = 2'd2,
        S_REPUSH = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;
`endif

    state_t     state;
    state_t     state_next;
    logic       port_q;     // granted port
    logic [1:0] op_q;       // granted op
    logic [7:0] word_q;     // push data; holds the popped word during a peek
    logic       err_q;      // granted op was rejected
    logic       rr_ptr;     // port that wins a contended grant

    logic       winner;
    logic [1:0] win_op;
    logic [7:0] win_wdata;
    logic       win_legal;

    // A lone requester wins regardless of the pointer; the pointer only
    // breaks ties.
    always_comb begin
        winner    = (req0 && req1) ? rr_ptr : req1;
        win_op    = winner ? op1 : op0;
        win_wdata = winner ? wdata1 : wdata0;
        win_legal = 1'b0;
        case (win_op)
            OP_PUSH: win_legal = !full;
            OP_POP:  win_legal = !empty;
`ifdef STACK_ARB_PEEK_EN
            OP_PEEK: win_legal = !empty;
`endif
            default: win_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (req0 || req1) begin
                    state_next = win_legal ? S_ISSUE : S_DONE;
                end
            end
            S_ISSUE: begin
`ifdef STACK_ARB_PEEK_EN
                state_next = (op_q == OP_PEEK) ? S_REPUSH : S_DONE;
`else
                state_next = S_DONE;
`endif
            end
`ifdef STACK_ARB_PEEK_EN
            S_REPUSH: state_next = S_DONE;
`endif
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Strobes and handshakes come from registered state only, so nothing
    // combinational from the requesters reaches the stack or the acks.
    always_comb begin
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        stk_value = 8'h00;
        if (state == S_ISSUE) begin
            if (op_q == OP_PUSH) begin
                stk_push  = 1'b1;
                stk_value = word_q;
            end else begin
                stk_pop = 1'b1;
            end
        end
`ifdef STACK_ARB_PEEK_EN
        if (state == S_REPUSH) begin
            stk_push  = 1'b1;
            stk_value = word_q;
        end
`endif
        ack0 = (state == S_DONE) && !port_q;
        ack1 = (state == S_DONE) && port_q;
        err0 = ack0 && err_q;
        err1 = ack1 && err_q;
    end

    assign full  = (depth == 9'd256);
    assign empty = (depth == 9'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            port_q <= 1'b0;
            op_q   <= OP_PUSH;
            word_q <= 8'h00;
            err_q  <= 1'b0;
            rr_ptr <= 1'b0;
            depth  <= 9'd0;
            rdata0 <= 8'h00;
            rdata1 <= 8'h00;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        port_q <= winner;
                        op_q   <= win_op;
                        word_q <= win_wdata;
                        err_q  <= !win_legal;
                        rr_ptr <= !winner;
                    end
                end
                S_ISSUE: begin
                    // Legality was checked in IDLE, so depth cannot leave 0..256.
                    if (op_q == OP_PUSH) begin
                        depth <= depth + 9'd1;
                    end else begin
                        word_q <= stk_output;
                        if (port_q) begin
                            rdata1 <= stk_output;
                        end else begin
                            rdata0 <= stk_output;
                        end
                        if (op_q == OP_POP) begin
                            depth <= depth - 9'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_arbiter.sv
// tb/tb_stack_arbiter.sv - self-checking bench for stack_arbiter with a behavioural stack and reference model

module tb_stack_arbiter;

    logic       clk;
    logic       rst;
    logic       req0, req1;
    logic [1:0] op0, op1;
    logic [7:0] wdata0, wdata1;
    logic       ack0, ack1, err0, err1;
    logic [7:0] rdata0, rdata1;
    logic       stk_pop, stk_push;
    logic [7:0] stk_value;
    logic [7:0] stk_output;
    logic [8:0] depth;
    logic       full, empty;

    int total = 0;
    int bad   = 0;

    stack_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .rdata0(rdata0), .rdata1(rdata1),
        .stk_pop(stk_pop), .stk_push(stk_push), .stk_value(stk_value),
        .stk_output(stk_output),
        .depth(depth), .full(full), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural STACK block on the other side of the strobes.
    logic [7:0] mem [0:255];
    logic [8:0] sp;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp <= 9'd0;
        end else if (stk_push) begin
            mem[sp[7:0]] <= stk_value;
            sp <= sp + 9'd1;
        end else if (stk_pop) begin
            sp <= sp - 9'd1;
        end
    end
    assign stk_output = (sp != 9'd0) ? mem[sp[7:0] - 8'd1] : 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One transaction on port p, checked cycle by cycle until its ack.
    task automatic do_op(input int p, input logic [1:0] o, input logic [7:0] wd,
                         input logic e_err, input int e_lat,
                         input logic [7:0] e_rd0, input logic [7:0] e_rd1,
                         input logic [8:0] e_dep);
        int n;
        int bad_cyc;
        logic got, sok, got_err, exp_push, exp_pop;
        logic [7:0] exp_val;
        @(negedge clk);
        if (p == 0) begin req0 = 1'b1; op0 = o; wdata0 = wd; end
        else        begin req1 = 1'b1; op1 = o; wdata1 = wd; end
        n = 0; got = 1'b0; sok = 1'b1; got_err = 1'b0; bad_cyc = 0;
        while (!got && n < 12) begin
            @(negedge clk);
            n++;
            exp_push = 1'b0; exp_pop = 1'b0; exp_val = 8'h00;
            if (!e_err && n < e_lat) begin
                if (o == 2'b00) begin
                    exp_push = 1'b1; exp_val = wd;
                end else if (n == 1) begin
                    exp_pop = 1'b1;
                end else begin
                    exp_push = 1'b1; exp_val = (p == 0) ? e_rd0 : e_rd1;
                end
            end
            if (sok && (stk_push !== exp_push || stk_pop !== exp_pop || stk_value !== exp_val)) begin
                sok = 1'b0; bad_cyc = n;
            end
            if ((p == 0 && ack1) || (p == 1 && ack0)) begin
                sok = 1'b0; bad_cyc = n;
            end
            if ((p == 0) ? ack0 : ack1) begin
                got = 1'b1;
                got_err = (p == 0) ? err0 : err1;
            end
        end
        if (p == 0) req0 = 1'b0; else req1 = 1'b0;
        chk($sformatf("ack p%0d op%0d", p, o), got, 1);
        chk($sformatf("latency p%0d op%0d", p, o), n, e_lat);
        chk($sformatf("err p%0d op%0d", p, o), got_err, e_err);
        chk($sformatf("strobes p%0d op%0d cycle%0d", p, o, bad_cyc), sok, 1);
        chk("rdata0", rdata0, e_rd0);
        chk("rdata1", rdata1, e_rd1);
        chk("depth", depth, e_dep);
        chk("full", full, e_dep == 9'd256);
        chk("empty", empty, e_dep == 9'd0);
    endtask

    typedef struct {
        int         p;
        logic [1:0] o;
        logic [7:0] wd;
        logic       e_err;
        int         e_lat;
        logic [7:0] rd0;
        logic [7:0] rd1;
        logic [8:0] dep;
    } vec_t;

    vec_t tbl [13];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ref_q [$];
        logic [7:0] ref_rd [2];
        int         nacks;
        logic       overlap, seen_ack;

        tbl[0]  = '{0, 2'b00, 8'hA5, 1'b0, 2, 8'h00, 8'h00, 9'd1};
        tbl[1]  = '{0, 2'b01, 8'h00, 1'b0, 2, 8'hA5, 8'h00, 9'd0};
        tbl[2]  = '{1, 2'b01, 8'h00, 1'b1, 1, 8'hA5, 8'h00, 9'd0};
        tbl[3]  = '{0, 2'b00, 8'h11, 1'b0, 2, 8'hA5, 8'h00, 9'd1};
        tbl[4]  = '{0, 2'b00, 8'h22, 1'b0, 2, 8'hA5, 8'h00, 9'd2};
        tbl[5]  = '{1, 2'b00, 8'h33, 1'b0, 2, 8'hA5, 8'h00, 9'd3};
        tbl[6]  = '{1, 2'b01, 8'h00, 1'b0, 2, 8'hA5, 8'h33, 9'd2};
        tbl[7]  = '{1, 2'b01, 8'h00, 1'b0, 2, 8'hA5, 8'h22, 9'd1};
        tbl[8]  = '{1, 2'b01, 8'h00, 1'b0, 2, 8'hA5, 8'h11, 9'd0};
        tbl[9]  = '{0, 2'b11, 8'h00, 1'b1, 1, 8'hA5, 8'h11, 9'd0};
        tbl[10] = '{0, 2'b00, 8'h7E, 1'b0, 2, 8'hA5, 8'h11, 9'd1};
`ifdef STACK_ARB_PEEK_EN
        tbl[11] = '{1, 2'b10, 8'h00, 1'b0, 3, 8'hA5, 8'h7E, 9'd1};
`else
        tbl[11] = '{1, 2'b10, 8'h00, 1'b1, 1, 8'hA5, 8'h11, 9'd1};
`endif
        tbl[12] = '{1, 2'b01, 8'h00, 1'b0, 2, 8'hA5, 8'h7E, 9'd0};

        rst = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        op0 = 2'b00; op1 = 2'b00;
        wdata0 = 8'h00; wdata1 = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset depth", depth, 0);
        chk("reset empty", empty, 1);
        chk("reset full", full, 0);
        chk("reset rdata0", rdata0, 0);
        chk("reset rdata1", rdata1, 0);
        chk("reset strobes", {stk_pop, stk_push, stk_value}, 0);
        chk("reset acks", {ack0, ack1, err0, err1}, 0);
        rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            do_op(tbl[i].p, tbl[i].o, tbl[i].wd, tbl[i].e_err, tbl[i].e_lat,
                  tbl[i].rd0, tbl[i].rd1, tbl[i].dep);
        end

        // Fill to capacity, then overflow.
        for (int i = 0; i < 256; i++) begin
            do_op(i % 2, 2'b00, i[7:0], 1'b0, 2, 8'hA5, 8'h7E, 9'(i + 1));
        end
        chk("full after 256", full, 1);
        do_op(1, 2'b00, 8'hFF, 1'b1, 1, 8'hA5, 8'h7E, 9'd256);
        do_op(0, 2'b01, 8'h00, 1'b0, 2, 8'hFF, 8'h7E, 9'd255);

        // Both ports held high with pushes: grants alternate starting at port 0.
        pulse_reset();
        @(negedge clk);
        req0 = 1'b1; req1 = 1'b1;
        op0 = 2'b00; op1 = 2'b00;
        wdata0 = 8'h01; wdata1 = 8'h02;
        nacks = 0; overlap = 1'b0;
        for (int c = 0; c < 40 && nacks < 6; c++) begin
            @(negedge clk);
            if (ack0 && ack1) begin
                overlap = 1'b1;
            end else if (ack0 || ack1) begin
                chk($sformatf("grant order %0d", nacks), ack1, nacks % 2);
                nacks++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("contended acks", nacks, 6);
        chk("ack overlap", overlap, 0);
        @(negedge clk);
        chk("contended depth", depth, 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("contended word %0d", i), mem[i], (i % 2) ? 8'h02 : 8'h01);
        end

        // Reset asserted while a push is in ISSUE.
        pulse_reset();
        @(negedge clk);
        req0 = 1'b1; op0 = 2'b00; wdata0 = 8'h5A;
        @(posedge clk);
        #1;
        chk("issue push strobe", stk_push, 1);
        chk("issue push value", stk_value, 8'h5A);
        #1;
        rst = 1'b0;
        #1;
        chk("reset drops strobes", {stk_push, stk_pop, stk_value}, 0);
        chk("reset clears depth", depth, 0);
        req0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        seen_ack = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (ack0 || ack1) seen_ack = 1'b1;
        end
        chk("no ack after reset", seen_ack, 0);
        chk("depth after reset", depth, 0);

        // Randomised single-port traffic against the reference model.
        pulse_reset();
        ref_rd[0] = 8'h00;
        ref_rd[1] = 8'h00;
        for (int k = 0; k < 150; k++) begin
            int p, r, sz, lat;
            logic [1:0] o;
            logic [7:0] wd;
            logic legal;
            p  = $urandom_range(0, 1);
            r  = $urandom_range(0, 99);
            wd = 8'($urandom);
            o  = (r < 45) ? 2'b00 : (r < 80) ? 2'b01 : (r < 93) ? 2'b10 : 2'b11;
            sz = ref_q.size();
            case (o)
                2'b00:   legal = (sz < 256);
                2'b01:   legal = (sz > 0);
`ifdef STACK_ARB_PEEK_EN
                2'b10:   legal = (sz > 0);
`endif
                default: legal = 1'b0;
            endcase
            lat = !legal ? 1 : (o == 2'b10) ? 3 : 2;
            if (legal) begin
                if (o == 2'b00)      ref_q.push_back(wd);
                else if (o == 2'b01) ref_rd[p] = ref_q.pop_back();
                else                 ref_rd[p] = ref_q[$];
            end
            do_op(p, o, wd, !legal, lat, ref_rd[0], ref_rd[1], 9'(ref_q.size()));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
